// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter that time-shares one combinational adder tree (stage3)
// among NUM_REQ requesters, with an operand slot and a result slot.
module adder_tree_arbiter #(
    parameter int NUM_REQ            = 3,
    parameter int STAGE_1_NUM_INPUTS = 4,
    parameter int STAGE_1_BIT_WIDTH  = 8,
    parameter int W_IN               = STAGE_1_BIT_WIDTH + STAGE_1_NUM_INPUTS - 1,
    parameter int W_OUT              = W_IN + $clog2(STAGE_1_NUM_INPUTS),
    parameter int ID_W               = $clog2(NUM_REQ)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_REQ-1:0]                                  req_valid,
    output logic [NUM_REQ-1:0]                                  req_ready,
    input  logic [NUM_REQ-1:0][STAGE_1_NUM_INPUTS-1:0][W_IN-1:0] req_data,
    output logic [STAGE_1_NUM_INPUTS-1:0][W_IN-1:0]             tree_in,
    input  logic [W_OUT-1:0]                                    tree_out,
    output logic                                                res_valid,
    input  logic                                                res_ready,
    output logic [W_OUT-1:0]                                    res_data,
    output logic [ID_W-1:0]                                     res_id,
    output logic                                                busy
);

    logic                                        op_valid_q, op_valid_d;
    logic [STAGE_1_NUM_INPUTS-1:0][W_IN-1:0]     op_data_q, op_data_d;
    logic [ID_W-1:0]                             op_id_q, op_id_d;
    logic                                        res_valid_q, res_valid_d;
    logic [W_OUT-1:0]                            res_data_q, res_data_d;
    logic [ID_W-1:0]                             res_id_q, res_id_d;
    logic [ID_W-1:0]                             last_grant_q, last_grant_d;

    logic                                        res_adv;
    logic                                        op_free;
    logic                                        grant_any;
    logic [ID_W-1:0]                             grant_idx;
    logic [NUM_REQ-1:0]                          grant_oh;

    assign res_adv = !res_valid_q || res_ready;
    assign op_free = !op_valid_q || res_adv;

    // Scan starts just after the last winner; reset blocks any transfer.
    always_comb begin
        logic [ID_W-1:0] cand;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        if (op_free && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_W'((int'(last_grant_q) + 1 + k) % NUM_REQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any      = 1'b1;
                    grant_idx      = cand;
                    grant_oh[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        op_valid_d   = op_valid_q;
        op_data_d    = op_data_q;
        op_id_d      = op_id_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;

        if (op_valid_q && res_adv) begin
            op_valid_d  = 1'b0;
            res_valid_d = 1'b1;
            res_data_d  = tree_out;
            res_id_d    = op_id_q;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        // A new grant may refill the op slot in the same cycle it drains.
        if (grant_any) begin
            op_valid_d   = 1'b1;
            op_data_d    = req_data[grant_idx];
            op_id_d      = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_valid_q   <= 1'b0;
            op_data_q    <= '0;
            op_id_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            op_valid_q   <= op_valid_d;
            op_data_q    <= op_data_d;
            op_id_q      <= op_id_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign req_ready = grant_oh;
    assign tree_in   = op_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = op_valid_q || res_valid_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Bench for adder_tree_arbiter: directed vector table plus randomized traffic,
// both scored against a queue-based transaction model.
module tb_adder_tree_arbiter;

    localparam int N     = 3;
    localparam int NI    = 4;
    localparam int W_IN  = 11;
    localparam int W_OUT = 13;
    localparam int ID_W  = 2;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [N-1:0]                      req_valid;
    logic [N-1:0]                      req_ready;
    logic [N-1:0][NI-1:0][W_IN-1:0]    req_data;
    logic [NI-1:0][W_IN-1:0]           tree_in;
    logic [W_OUT-1:0]                  tree_out;
    logic                              res_valid;
    logic                              res_ready;
    logic [W_OUT-1:0]                  res_data;
    logic [ID_W-1:0]                   res_id;
    logic                              busy;

    adder_tree_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .tree_in(tree_in), .tree_out(tree_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared stage3 tree: plain unsigned sum.
    always_comb begin
        tree_out = '0;
        for (int i = 0; i < NI; i++) tree_out = tree_out + W_OUT'(tree_in[i]);
    end

    typedef struct packed {
        logic             rst;
        logic [N-1:0]     vld;
        logic             rdy;
        logic [N-1:0]     gnt;
        logic             rv;
        logic [W_OUT-1:0] rd;
        logic [ID_W-1:0]  rid;
        logic             bsy;
        logic             chk_d;
    } vec_t;

    typedef struct {
        int id;
        int sum;
        int tag;
    } item_t;

    int    checks   = 0;
    int    failures = 0;
    item_t mq[$];
    int    m_last   = N - 1;
    int    now      = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, now, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic [N-1:0] vl, input logic rd_y,
                               input logic [N-1:0] g, input logic rvl, input int d,
                               input int id, input logic b, input logic cd);
        vec_t t;
        t.rst = r; t.vld = vl; t.rdy = rd_y; t.gnt = g; t.rv = rvl;
        t.rd = W_OUT'(d); t.rid = ID_W'(id); t.bsy = b; t.chk_d = cd;
        return t;
    endfunction

    function automatic int vec_sum(input int r);
        int s = 0;
        for (int i = 0; i < NI; i++) s += int'(req_data[r][i]);
        return s;
    endfunction

    // One cycle: settle, compare against the model (and table row), advance.
    task automatic step(input bit has_row, input vec_t row);
        logic [N-1:0] exp_gnt;
        bit           exp_rv;
        int           g;
        #1;
        exp_gnt = '0;
        g = -1;
        if (!rst && (mq.size() < 2 || res_ready)) begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) exp_gnt[g] = 1'b1;
        end
        exp_rv = (mq.size() > 0) && (mq[0].tag + 1 < now);

        check("model_req_ready", int'(req_ready), int'(exp_gnt));
        check("model_res_valid", int'(res_valid), int'(exp_rv));
        check("model_busy", int'(busy), int'(mq.size() > 0));
        if (exp_rv && res_valid) begin
            check("model_res_data", int'(res_data), mq[0].sum);
            check("model_res_id", int'(res_id), mq[0].id);
        end

        if (has_row) begin
            check("tbl_req_ready", int'(req_ready), int'(row.gnt));
            check("tbl_res_valid", int'(res_valid), int'(row.rv));
            check("tbl_busy", int'(busy), int'(row.bsy));
            if (row.rv || row.chk_d) begin
                check("tbl_res_data", int'(res_data), int'(row.rd));
                check("tbl_res_id", int'(res_id), int'(row.rid));
            end
            if (row.chk_d) check("tbl_tree_in_zero", int'(tree_in), 0);
        end

        if (rst) begin
            mq.delete();
            m_last = N - 1;
        end else begin
            if (exp_rv && res_ready) void'(mq.pop_front());
            if (g >= 0) begin
                item_t it;
                it.id = g; it.sum = vec_sum(g); it.tag = now;
                mq.push_back(it);
                m_last = g;
            end
        end
        now++;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[30];

    initial begin
        tbl[0]  = v(1, 3'b000, 1, 3'b000, 0, 0,      0, 0, 1);
        tbl[1]  = v(1, 3'b111, 1, 3'b000, 0, 0,      0, 0, 1);
        tbl[2]  = v(0, 3'b111, 1, 3'b001, 0, 0,      0, 0, 0);
        tbl[3]  = v(0, 3'b000, 1, 3'b000, 0, 0,      0, 1, 0);
        tbl[4]  = v(0, 3'b010, 1, 3'b010, 1, 'h1FFC, 0, 1, 0);
        tbl[5]  = v(0, 3'b000, 1, 3'b000, 0, 0,      0, 1, 0);
        tbl[6]  = v(0, 3'b000, 1, 3'b000, 1, 10,     1, 1, 0);
        tbl[7]  = v(1, 3'b000, 1, 3'b000, 0, 0,      0, 0, 0);
        tbl[8]  = v(0, 3'b111, 1, 3'b001, 0, 0,      0, 0, 1);
        tbl[9]  = v(0, 3'b111, 1, 3'b010, 0, 0,      0, 1, 0);
        tbl[10] = v(0, 3'b111, 1, 3'b100, 1, 'h1FFC, 0, 1, 0);
        tbl[11] = v(0, 3'b111, 1, 3'b001, 1, 10,     1, 1, 0);
        tbl[12] = v(0, 3'b111, 1, 3'b010, 1, 1000,   2, 1, 0);
        tbl[13] = v(0, 3'b111, 1, 3'b100, 1, 'h1FFC, 0, 1, 0);
        tbl[14] = v(0, 3'b000, 1, 3'b000, 1, 10,     1, 1, 0);
        tbl[15] = v(0, 3'b000, 1, 3'b000, 1, 1000,   2, 1, 0);
        tbl[16] = v(0, 3'b000, 1, 3'b000, 0, 0,      0, 0, 0);
        tbl[17] = v(0, 3'b111, 0, 3'b001, 0, 0,      0, 0, 0);
        tbl[18] = v(0, 3'b111, 0, 3'b010, 0, 0,      0, 1, 0);
        tbl[19] = v(0, 3'b111, 0, 3'b000, 1, 'h1FFC, 0, 1, 0);
        tbl[20] = v(0, 3'b111, 0, 3'b000, 1, 'h1FFC, 0, 1, 0);
        tbl[21] = v(0, 3'b111, 0, 3'b000, 1, 'h1FFC, 0, 1, 0);
        tbl[22] = v(0, 3'b000, 1, 3'b000, 1, 'h1FFC, 0, 1, 0);
        tbl[23] = v(0, 3'b000, 1, 3'b000, 1, 10,     1, 1, 0);
        tbl[24] = v(0, 3'b100, 1, 3'b100, 0, 0,      0, 0, 0);
        tbl[25] = v(1, 3'b000, 1, 3'b000, 0, 0,      0, 1, 0);
        tbl[26] = v(0, 3'b111, 1, 3'b001, 0, 0,      0, 0, 1);
        tbl[27] = v(0, 3'b000, 1, 3'b000, 0, 0,      0, 1, 0);
        tbl[28] = v(0, 3'b000, 1, 3'b000, 1, 'h1FFC, 0, 1, 0);
        tbl[29] = v(0, 3'b000, 1, 3'b000, 0, 0,      0, 0, 0);

        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req_data[0][i] = 11'h7FF;
            req_data[1][i] = W_IN'(i + 1);
            req_data[2][i] = W_IN'(100 * (i + 1));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            rst       = tbl[i].rst;
            req_valid = tbl[i].vld;
            res_ready = tbl[i].rdy;
            step(1'b1, tbl[i]);
        end

        // Randomized traffic with fresh operands every cycle and rare resets.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            res_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < N; r++)
                for (int p = 0; p < NI; p++)
                    req_data[r][p] = W_IN'($urandom_range(0, 2047));
            step(1'b0, tbl[0]);
        end

        // Saturated phase: everyone valid, occasional stalls, fairness via model.
        for (int i = 0; i < 60; i++) begin
            rst       = 1'b0;
            req_valid = '1;
            res_ready = ($urandom_range(0, 4) != 0);
            for (int r = 0; r < N; r++)
                for (int p = 0; p < NI; p++)
                    req_data[r][p] = W_IN'($urandom_range(0, 2047));
            step(1'b0, tbl[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
